// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; the single adder resource the sequencer time-shares.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: latches operands on a start edge, adds LSB first
// over WIDTH cycles through one full-adder cell, then presents sum/cout with a done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               start_q;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_edge;
  logic               fa_s, fa_cout;

  assign start_edge = start & ~start_q;

  full_adder_bit u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the case leaves it unassigned (no latch).
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        // Sum bits enter at the MSB so the first (LSB) bit ends up at bit 0 after WIDTH shifts.
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = fa_s;
        cnt_d             = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = res_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      start_q <= start;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results, a monitor checks each done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_cmp = 0;
  int        n_fail = 0;
  int        cyc = 0;
  int        done_pulses = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      sb_entry_t e;
      done_pulses++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issues one operation from IDLE and waits (bounded) for its done pulse.
  // hold keeps start high; inj >= 0 raises a second start edge that many cycles into RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic [W-1:0] esum, input logic ecout, input bit hold, input int inj);
    sb_entry_t e;
    int busy_n;
    bit got;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    start = 1'b1;
    e.sum  = esum;
    e.cout = ecout;
    e.due  = cyc + 1 + W;
    sb.push_back(e);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) start = 1'b0;
      if (i == inj) begin
        a = 1; b = 1; cin = 1'b0; start = 1'b1;
      end
      if (inj >= 0 && i == inj + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'(1));
    check("busy_cycles", 32'(busy_n), 32'(W));
    @(negedge clk);
  endtask

  initial begin
    int dp0;
    logic [W:0] total;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    rst = 1'b0;

    // Basic: 5 + 3 = 8
    run_op(4'd5, 4'd3, 1'b0, 4'b1000, 1'b0, 1'b0, -1);

    // Overflow onto cout, and sum holds between operations
    run_op(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("sum_hold", 32'(sum), 32'(0));
    check("cout_hold", 32'(cout), 32'(1));
    run_op(4'd7, 4'd8, 1'b1, 4'd0, 1'b1, 1'b0, -1);

    // Level-held start runs exactly once
    dp0 = done_pulses;
    run_op(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b1, -1);
    repeat (15) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start_pulses", 32'(done_pulses - dp0), 32'(1));
    check("held_start_sum", 32'(sum), 32'(4));

    // Start edge during RUN is ignored; operands changed after acceptance have no effect
    dp0 = done_pulses;
    run_op(4'd6, 4'd5, 1'b0, 4'd11, 1'b0, 1'b0, 2);
    repeat (8) @(negedge clk);
    check("ignored_edge_pulses", 32'(done_pulses - dp0), 32'(1));

    // Reset two cycles into RUN aborts at once
    dp0 = done_pulses;
    @(negedge clk);
    a = 4'd15; b = 4'd15; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sum", 32'(sum), 32'(0));
    check("abort_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_pulses - dp0), 32'(0));
    run_op(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, -1);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          total = (W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic);
          run_op(W'(ia), W'(ib), 1'(ic), total[W-1:0], total[W], 1'b0, -1);
        end
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
